// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared constants, types and helpers for the data-memory
//             latency model (line width, address offset, FSM encoding).
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // One cache line is 256 bits = 32 bytes, so the low 5 address bits
    // select a byte within the line and are ignored by the memory.
    localparam int LINE_W      = 256;
    localparam int OFFSET_W    = 5;

    // Default geometry and timing of the memory stage.
    localparam int DEF_LATENCY = 10;
    localparam int DEF_DEPTH   = 512;
    localparam int DEF_IDX_W   = 9;

    // Latency counter width; LATENCY is limited to 1..255.
    localparam int CNT_W       = 8;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [1:0]        state_t;

    // FSM encoding.
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ACK  = 2'd2;

    // Line number of a byte address (byte offset stripped).
    function automatic logic [31:0] line_of(input logic [31:0] addr);
        return addr >> OFFSET_W;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_latency_model_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_latency_model_if
//  Purpose  : Cache <-> backing-memory request/response bundle. The cache
//             side uses the master modport, the memory the slave modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_latency_model_if;
    import dmem_pkg::*;

    logic [31:0] addr_i;
    line_t       data_i;
    logic        enable_i;
    logic        write_i;
    logic        ack_o;
    line_t       data_o;
    logic        busy_o;

    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output ack_o, data_o, busy_o
    );

endinterface : dmem_latency_model_if
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_line_array
//  Purpose  : DEPTH x 256-bit line storage. Synchronous write, combinational
//             read at the same index. Contents are deliberately not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  wire              clk_i,
    input  wire              i_we,
    input  wire [IDX_W-1:0]  i_idx,
    input  wire [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    line_t r_mem [DEPTH];

    // Commit a line on the write strobe; no reset so the array maps to RAM.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule : dmem_line_array
`default_nettype wire

// File: rtl/dmem_latency_model.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_latency_model
//  Purpose  : Main-memory stage behind the data cache. Accepts one line
//             read/write request in IDLE, holds it for LATENCY cycles, then
//             commits the write or returns the read line with a one-cycle ack.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_latency_model
    import dmem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  wire                    clk_i,
    input  wire                    rst_i,
    dmem_latency_model_if.slave    bus
);

    // Counter preload: the request is accepted at E0 and the commit edge is
    // E0+LATENCY, so LATENCY-1 more decrements follow the load.
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    line_t             r_wdata;
    logic              r_write;
    logic              r_ack;
    logic              r_busy;
    line_t             r_rdata;

    logic [31:0]       w_line;
    logic              w_commit;
    logic              w_we;
    line_t             w_array_rdata;
    logic              w_unused;

    assign w_line   = line_of(bus.addr_i);
    // Address bits above the index wrap, so they are intentionally dropped.
    assign w_unused = &{1'b0, w_line[31:IDX_W]};

    assign w_commit = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_we     = w_commit && r_write;

    dmem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_array_rdata)
    );

    // Request latch: capture index, data and direction only when accepted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if ((r_state == ST_IDLE) && bus.enable_i) begin
            r_idx   <= w_line[IDX_W-1:0];
            r_wdata <= bus.data_i;
            r_write <= bus.write_i;
        end
    end

    // Control FSM with latency counter, ack pulse, busy flag and read register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable_i) begin
                        r_cnt   <= C_CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_commit) begin
                        // Writes leave the read register untouched.
                        if (!r_write) begin
                            r_rdata <= w_array_rdata;
                        end
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    // enable_i is not looked at here; a held request is
                    // picked up on the first edge back in IDLE.
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o  = r_ack;
    assign bus.busy_o = r_busy;
    assign bus.data_o = r_rdata;

endmodule : dmem_latency_model
`default_nettype wire
